// File: rtl/ask_frame_ctrl.sv
// ASK (on/off keyed) frame transmitter: LFSR preamble, 8 data bits MSB first, one stop bit.
// Each bit lasts SPB clocks. The carrier is gated onto the DAC through a two-stage sine-ROM pipeline.
module ask_frame_ctrl #(
    parameter int          SPB      = 256,
    parameter int          PRE_LEN  = 15,
    parameter logic [7:0]  IDLE_LVL = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       abort,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_q,
    output logic       carrier_en,
    output logic [7:0] dac_data,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_STOP} state_t;

    localparam logic [15:0] SPB_LAST = 16'(SPB - 1);
    localparam logic [3:0]  PRE_LAST = 4'(PRE_LEN - 1);
    localparam logic [3:0]  LFSR_SEED = 4'b1000;

    state_t      state_q, state_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic        carrier_en_q, carrier_en_d;
    logic        en_d1_q, en_d1_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [7:0]  dac_data_q, dac_data_d;
    logic        frame_done_q, frame_done_d;
    logic        bit_end;
    logic [15:0] sample_inc;

    assign bit_end    = (sample_cnt_q == SPB_LAST);
    assign sample_inc = bit_end ? 16'd0 : sample_cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        lfsr_d       = lfsr_q;
        carrier_en_d = carrier_en_q;
        frame_done_d = 1'b0;
        en_d1_d      = carrier_en_q;
        dac_data_d   = en_d1_q ? rom_q : IDLE_LVL;

        if (abort) begin
            state_d      = S_IDLE;
            sample_cnt_d = 16'd0;
            bit_cnt_d    = 4'd0;
            carrier_en_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    sample_cnt_d = 16'd0;
                    bit_cnt_d    = 4'd0;
                    carrier_en_d = 1'b0;
                    if (tx_valid) begin
                        state_d      = S_PRE;
                        byte_d       = tx_data;
                        lfsr_d       = LFSR_SEED;
                        carrier_en_d = LFSR_SEED[3];
                    end
                end
                S_PRE: begin
                    sample_cnt_d = sample_inc;
                    if (bit_end) begin
                        lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
                        if (bit_cnt_q == PRE_LAST) begin
                            state_d      = S_DATA;
                            bit_cnt_d    = 4'd0;
                            carrier_en_d = byte_q[7];
                        end else begin
                            bit_cnt_d    = bit_cnt_q + 4'd1;
                            carrier_en_d = lfsr_d[3];
                        end
                    end
                end
                S_DATA: begin
                    sample_cnt_d = sample_inc;
                    if (bit_end) begin
                        if (bit_cnt_q == 4'd7) begin
                            state_d      = S_STOP;
                            bit_cnt_d    = 4'd0;
                            carrier_en_d = 1'b0;
                        end else begin
                            // byte_q is shifted so bit 7 is always the bit on air
                            byte_d       = {byte_q[6:0], 1'b0};
                            bit_cnt_d    = bit_cnt_q + 4'd1;
                            carrier_en_d = byte_q[6];
                        end
                    end
                end
                S_STOP: begin
                    sample_cnt_d = sample_inc;
                    if (bit_end) begin
                        state_d      = S_IDLE;
                        sample_cnt_d = 16'd0;
                        carrier_en_d = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        rom_addr_d = sample_cnt_d[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= 16'd0;
            bit_cnt_q    <= 4'd0;
            byte_q       <= 8'd0;
            lfsr_q       <= LFSR_SEED;
            carrier_en_q <= 1'b0;
            en_d1_q      <= 1'b0;
            rom_addr_q   <= 8'd0;
            dac_data_q   <= IDLE_LVL;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_q       <= byte_d;
            lfsr_q       <= lfsr_d;
            carrier_en_q <= carrier_en_d;
            en_d1_q      <= en_d1_d;
            rom_addr_q   <= rom_addr_d;
            dac_data_q   <= dac_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign carrier_en = carrier_en_q;
    assign rom_addr   = rom_addr_q;
    assign dac_data   = dac_data_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ask_frame_ctrl.sv
// Bench for ask_frame_ctrl: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with abort/reset.
module tb_ask_frame_ctrl;
    localparam int SPB = 4;
    localparam int PRE = 5;
    localparam int NFR = (PRE + 9) * SPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rom_q = 8'h00;
    logic       tx_ready, carrier_en, busy, frame_done;
    logic [7:0] rom_addr, dac_data;

    int checks = 0;
    int failures = 0;

    ask_frame_ctrl #(.SPB(SPB), .PRE_LEN(PRE), .IDLE_LVL(8'h80)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .abort(abort), .rom_addr(rom_addr), .rom_q(rom_q), .carrier_en(carrier_en),
        .dac_data(dac_data), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // ROM stand-in: data equals the address presented one clock earlier
    always @(posedge clk) rom_q <= rom_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just a position k within (PRE+9)*SPB cycles
    bit         pre_seq[PRE];
    bit         m_valid = 0, m_active = 0, m_done = 0;
    int         m_k = 0;
    logic [7:0] m_byte = 8'h00;
    bit         c1 = 0, c2 = 0;
    logic [7:0] a1 = 8'h00, a2 = 8'h00, m_dac = 8'h80;

    function automatic bit bit_of(input int b, input logic [7:0] d);
        if (b < PRE) return pre_seq[b];
        if (b < PRE + 8) return d[7 - (b - PRE)];
        return 1'b0;
    endfunction

    function automatic bit exp_car();
        return m_active ? bit_of(m_k / SPB, m_byte) : 1'b0;
    endfunction

    function automatic logic [7:0] exp_addr();
        return m_active ? 8'(m_k % SPB) : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_active = 0; m_done = 0; m_dac = 8'h80;
            c1 = 0; c2 = 0; a1 = 8'h00; a2 = 8'h00;
        end else begin
            m_dac = c2 ? a2 : 8'h80;
            m_done = 0;
            if (abort) m_active = 0;
            else if (m_active) begin
                m_k++;
                if (m_k == NFR) begin m_active = 0; m_done = 1; end
            end else if (tx_valid) begin
                m_active = 1; m_k = 0; m_byte = tx_data;
            end
            c2 = c1; a2 = a1;
            c1 = exp_car(); a1 = exp_addr();
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx_ready", tx_ready, !m_active);
            chk("busy", busy, m_active);
            chk("carrier_en", carrier_en, exp_car());
            chk("rom_addr", rom_addr, exp_addr());
            chk("dac_data", dac_data, m_dac);
            chk("frame_done", frame_done, m_done);
        end
    end

    initial begin
        logic [3:0]  lfsr;
        logic [13:0] vec, vec2;
        logic [4:0]  v5;
        int          fd_cnt, c;

        lfsr = 4'b1000;
        for (int i = 0; i < PRE; i++) begin
            pre_seq[i] = lfsr[3];
            lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end

        // reset held for two edges
        repeat (2) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_carrier", carrier_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_dac", dac_data, 8'h80);
        chk("rst_frame_done", frame_done, 0);
        rst = 0;

        // single frame 0xA5
        tx_valid = 1; tx_data = 8'hA5;
        @(negedge clk);
        tx_valid = 0;
        fd_cnt = 0; vec = '0;
        for (int k = 0; k < 62; k++) begin
            if (k < NFR && k % SPB == 0) vec[13 - k / SPB] = carrier_en;
            if (k < 8) chk("a5_rom_addr", rom_addr, k % SPB);
            if (frame_done) begin
                fd_cnt++;
                chk("a5_done_cycle", k, NFR);
                chk("a5_busy_at_done", busy, 0);
            end
            @(negedge clk);
        end
        chk("a5_bits", vec, 14'b10001_10100101_0);
        chk("a5_done_count", fd_cnt, 1);

        // back-to-back frames with tx_valid held
        tx_valid = 1; tx_data = 8'h3C;
        @(negedge clk);
        c = 0; vec = '0;
        while (!frame_done && c < 200) begin
            if (c < NFR && c % SPB == 0) vec[13 - c / SPB] = carrier_en;
            if (c == 8) tx_data = 8'hC3;
            @(negedge clk);
            c++;
        end
        if (!frame_done) chk("b2b_timeout", 0, 1);
        chk("b2b_done_cycle", c, NFR);
        chk("b2b_ready_at_done", tx_ready, 1);
        chk("b2b_bits1", vec, {5'b10001, 8'h3C, 1'b0});
        @(negedge clk);
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_carrier", carrier_en, 1);
        tx_valid = 0;
        vec2 = '0;
        for (int k = 0; k < NFR; k++) begin
            if (k % SPB == 0) vec2[13 - k / SPB] = carrier_en;
            @(negedge clk);
        end
        chk("b2b_bits2", vec2, {5'b10001, 8'hC3, 1'b0});
        repeat (3) @(negedge clk);

        // abort during third data bit
        tx_valid = 1; tx_data = 8'hA5;
        @(negedge clk);
        tx_valid = 0;
        repeat (29) @(negedge clk);
        chk("abort_pre_carrier", carrier_en, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_carrier", carrier_en, 0);
        chk("abort_rom_addr", rom_addr, 0);
        chk("abort_frame_done", frame_done, 0);
        repeat (2) @(negedge clk);
        chk("abort_dac_idle", dac_data, 8'h80);
        fd_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (frame_done) fd_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", fd_cnt, 0);

        // reset in preamble with tx_valid held
        tx_valid = 1; tx_data = 8'h5A;
        @(negedge clk);
        repeat (6) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mrst_tx_ready", tx_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_carrier", carrier_en, 0);
        chk("mrst_rom_addr", rom_addr, 0);
        chk("mrst_dac", dac_data, 8'h80);
        rst = 0;
        @(negedge clk);
        tx_valid = 0;
        v5 = '0;
        for (int k = 0; k < 5 * SPB; k++) begin
            if (k % SPB == 0) v5[4 - k / SPB] = carrier_en;
            @(negedge clk);
        end
        chk("mrst_preamble", v5, 5'b10001);
        repeat (NFR) @(negedge clk);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom % 400) == 0;
            abort    = ($urandom % 150) == 0;
            tx_valid = ($urandom % 3) != 0;
            tx_data  = 8'($urandom);
            @(negedge clk);
        end
        rst = 0; abort = 0; tx_valid = 0;
        repeat (NFR + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ask_frame_ctrl.md
ASK_FRAME_CTRL -- requirements
Module: ask_frame_ctrl

Interface
- REQ-001: Parameter SPB, default 256: samples (clk cycles) per symbol bit; legal range 2..65535.
- REQ-002: Parameter PRE_LEN, default 15: number of preamble bits; legal range 1..15.
- REQ-003: Parameter IDLE_LVL, default 8'h80: DAC code driven while the carrier is off.
- REQ-004: clk  in  1  single clock; all state changes on its rising edge.
- REQ-005: rst  in  1  reset, synchronous, active-high.
- REQ-006: tx_data  in  8  payload byte, sampled on accept.
- REQ-007: tx_valid  in  1  payload offered.
- REQ-008: tx_ready  out  1  controller can accept a byte; high exactly when the state is IDLE.
- REQ-009: abort  in  1  terminate any frame in progress.
- REQ-010: rom_addr  out  8  sine ROM address; registered.
- REQ-011: rom_q  in  8  sine ROM data, valid one clk after rom_addr.
- REQ-012: carrier_en  out  1  current symbol bit (1 = carrier on); registered, aligned with rom_addr.
- REQ-013: dac_data  out  8  modulated sample to DAC; registered.
- REQ-014: busy  out  1  state != IDLE.
- REQ-015: frame_done  out  1  one-cycle pulse at normal frame completion.

Function
- REQ-016: The FSM SHALL have states IDLE, PRE, DATA, STOP; a byte is accepted on an edge where tx_valid & tx_ready & ~abort.
- REQ-017: On accept: state<=PRE, sample_cnt<=0, bit_cnt<=0, byte latched, LFSR<=4'b1000, carrier_en<=1 (first preamble bit).
- REQ-018: Every bit SHALL last exactly SPB cycles; sample_cnt counts 0..SPB-1 and wraps to 0 at each bit boundary.
- REQ-019: rom_addr SHALL equal sample_cnt[7:0] (wrapping mod 256 within a bit); rom_addr SHALL be 0 in IDLE.
- REQ-020: Preamble LFSR: next = {lfsr[2:0], lfsr[3]^lfsr[2]}; bit output = lfsr[3]; advances once per bit boundary; first five bits are 1,0,0,0,1.
- REQ-021: After PRE_LEN preamble bits: DATA, 8 bits of the latched byte, MSB first.
- REQ-022: After the 8th data bit: STOP, one bit period with carrier_en=0.
- REQ-023: At the last cycle of STOP: state<=IDLE, frame_done<=1 for one cycle; total frame length (PRE_LEN+9)*SPB cycles from the first cycle after accept.
- REQ-024: No new byte is accepted while busy; tx_valid held high during a frame is accepted on the first edge in IDLE (the cycle frame_done is high).
- REQ-025: Carrier-gating pipeline: carrier_en delayed 1 cycle (en_d1); dac_data <= en_d1 ? rom_q : IDLE_LVL; dac_data reflects the rom_addr of 2 cycles earlier.
- REQ-026: abort high on any edge: state<=IDLE, carrier_en<=0, rom_addr<=0, no frame_done; abort beats a simultaneous accept.
- REQ-027: abort while IDLE: no effect other than blocking accept.

Reset
- REQ-028: rst (sync, active-high) SHALL take priority over abort and accept and force: state IDLE, tx_ready=1 after the edge, busy=0, carrier_en=0, en_d1=0, rom_addr=0, dac_data=IDLE_LVL, frame_done=0, counters 0, LFSR 4'b1000.
- REQ-029: rst mid-frame SHALL discard the frame with no frame_done; the next accept restarts the preamble from the seed.

Verification (SPB=4, PRE_LEN=5, ROM model: rom_q = rom_addr of previous cycle)
- REQ-030: rst held 2 cycles -> tx_ready=1, busy=0, carrier_en=0, rom_addr=0, dac_data=8'h80, frame_done=0.
- REQ-031: Send 8'hA5 -> carrier_en per 4-cycle bit: 1,0,0,0,1 | 1,0,1,0,0,1,0,1 | 0; rom_addr cycles 0,1,2,3; frame_done pulses once 56 cycles after accept; busy low in the same cycle.
- REQ-032: tx_valid held high with 8'h3C then 8'hC3 -> second byte accepted on the frame_done cycle; no gap beyond that cycle; both payloads correct.
- REQ-033: abort during the 3rd data bit -> next cycle IDLE, carrier_en=0, rom_addr=0, no frame_done; dac_data=8'h80 two cycles later.
- REQ-034: rst asserted in PRE with tx_valid=1 -> reset values; re-accept after release; first bits 1,0,0,0,1.
- REQ-035: dac_data check over a full frame -> dac_data equals rom_addr from 2 cycles earlier when en_d1=1, else 8'h80.
